// File: rtl/mc_cu.sv
// mc_cu: multi-cycle control unit for the EI332 MIPS subset.
// Five-state IF/ID/EXE/MEM/WB sequencer with memory wait states.
module mc_cu #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit EXT_ISA       = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             z,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             wreg,
    output logic             wmem,
    output logic             iord,
    output logic [1:0]       pcsource,
    output logic [3:0]       aluc,
    output logic             shift,
    output logic             aluimm,
    output logic             sext,
    output logic             regrt,
    output logic             m2reg,
    output logic             jal,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EXE = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic r_type;
    logic i_add, i_sub, i_and, i_or, i_xor;
    logic i_sll, i_srl, i_sra, i_jr, i_slt;
    logic i_addi, i_andi, i_ori, i_xori, i_lui, i_slti;
    logic i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
    logic legal, ready, retire;
    logic [2:0] next_state;

    assign r_type = (op == 6'b000000);
    assign i_add  = r_type & (func == 6'b100000);
    assign i_sub  = r_type & (func == 6'b100010);
    assign i_and  = r_type & (func == 6'b100100);
    assign i_or   = r_type & (func == 6'b100101);
    assign i_xor  = r_type & (func == 6'b100110);
    assign i_sll  = r_type & (func == 6'b000000);
    assign i_srl  = r_type & (func == 6'b000010);
    assign i_sra  = r_type & (func == 6'b000011);
    assign i_jr   = r_type & (func == 6'b001000);
    assign i_slt  = EXT_ISA & r_type & (func == 6'b101010);
    assign i_addi = (op == 6'b001000);
    assign i_andi = (op == 6'b001100);
    assign i_ori  = (op == 6'b001101);
    assign i_xori = (op == 6'b001110);
    assign i_lui  = (op == 6'b001111);
    assign i_slti = EXT_ISA & (op == 6'b001010);
    assign i_lw   = (op == 6'b100011);
    assign i_sw   = (op == 6'b101011);
    assign i_beq  = (op == 6'b000100);
    assign i_bne  = (op == 6'b000101);
    assign i_j    = (op == 6'b000010);
    assign i_jal  = (op == 6'b000011);

    assign legal = i_add | i_sub | i_and | i_or | i_xor
                 | i_sll | i_srl | i_sra | i_jr | i_slt
                 | i_addi | i_andi | i_ori | i_xori | i_lui
                 | i_slti | i_lw | i_sw | i_beq | i_bne
                 | i_j | i_jal;

    assign ready = mem_ready | ~MEM_HANDSHAKE;

    assign shift  = i_sll | i_srl | i_sra;
    assign aluimm = i_addi | i_andi | i_ori | i_xori | i_lui
                  | i_slti | i_lw | i_sw;
    assign sext   = i_addi | i_slti | i_lw | i_sw | i_beq | i_bne;
    assign regrt  = i_addi | i_andi | i_ori | i_xori | i_lui
                  | i_slti | i_lw;
    assign m2reg  = i_lw;
    assign jal    = i_jal;

    assign aluc[3] = i_sra | i_slt | i_slti;
    assign aluc[2] = i_sub | i_or | i_srl | i_sra | i_ori
                   | i_lui | i_beq | i_bne;
    assign aluc[1] = i_xor | i_sll | i_srl | i_sra | i_xori
                   | i_lui | i_slt | i_slti;
    assign aluc[0] = i_and | i_or | i_sll | i_srl | i_sra
                   | i_andi | i_ori | i_slt | i_slti;

    // Enables are state-decoded and forced low during reset.
    always_comb begin
        next_state = S_IF;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        wreg       = 1'b0;
        wmem       = 1'b0;
        iord       = 1'b0;
        pcsource   = 2'd0;
        illegal    = 1'b0;
        retire     = 1'b0;
        if (!reset) begin
            case (state)
                S_IF: begin
                    if (ready) begin
                        irwrite    = 1'b1;
                        pcwrite    = 1'b1;
                        next_state = S_ID;
                    end else begin
                        next_state = S_IF;
                    end
                end
                S_ID: begin
                    unique case (1'b1)
                        i_j: begin
                            pcwrite  = 1'b1;
                            pcsource = 2'd3;
                            retire   = 1'b1;
                        end
                        i_jal: begin
                            pcwrite  = 1'b1;
                            pcsource = 2'd3;
                            wreg     = 1'b1;
                            retire   = 1'b1;
                        end
                        i_jr: begin
                            pcwrite  = 1'b1;
                            pcsource = 2'd2;
                            retire   = 1'b1;
                        end
                        !legal: illegal = 1'b1;
                        default: next_state = S_EXE;
                    endcase
                end
                S_EXE: begin
                    if (i_beq | i_bne) begin
                        pcwrite  = (i_beq & z) | (i_bne & ~z);
                        pcsource = 2'd1;
                        retire   = 1'b1;
                    end else if (i_lw | i_sw) begin
                        next_state = S_MEM;
                    end else begin
                        next_state = S_WB;
                    end
                end
                S_MEM: begin
                    iord = 1'b1;
                    wmem = i_sw;
                    if (!ready) begin
                        next_state = S_MEM;
                    end else if (i_lw) begin
                        next_state = S_WB;
                    end else begin
                        retire = 1'b1;
                    end
                end
                S_WB: begin
                    wreg   = 1'b1;
                    retire = 1'b1;
                end
                default: next_state = S_IF;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IF;
            retired <= '0;
        end else begin
            state <= next_state;
            if (retire) begin
                retired <= retired + ONE;
            end
        end
    end

endmodule
